// File: rtl/clk_pkg.sv
// Shared clock-family constants and the freq_meter FSM state type.
package clk_pkg;

  localparam int unsigned CLK_HZ              = 100_000_000;
  localparam int unsigned DEFAULT_GATE_CYCLES = CLK_HZ;

  // FLUSH spans exactly FLUSH_LAST+1 cycles while the sync/edge pipeline fills.
  localparam logic [1:0]  FLUSH_LAST          = 2'd2;

  typedef enum logic {
    FLUSH   = 1'b0,
    MEASURE = 1'b1
  } fm_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus edge register for an asynchronous input.
// level_o is the synchronized level; rise_o is high for one cycle per rising edge.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of measured_signal over a fixed gate and reports edges-per-gate.
// Optional period measurement is built when FREQ_METER_PERIOD_EN is defined.
module freq_meter
  import clk_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int          CNT_W       = 27
) (
  input  logic             incoming_CLK100MHZ,
  input  logic             reset,
  input  logic             measured_signal,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             overflow,
`ifdef FREQ_METER_PERIOD_EN
  output logic [CNT_W-1:0] period_cycles,
  output logic             period_valid,
`endif
  output logic             dbg_state_o,
  output logic             dbg_level_o
);

  // Handshake: count_valid (and period_valid) are one-cycle strobes with no ready;
  // the paired data output holds its value until the next strobe.

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  fm_state_t        state_q, state_d;
  logic [1:0]       flush_ctr_q, flush_ctr_d;
  logic [GW-1:0]    gate_ctr_q, gate_ctr_d;
  logic [CNT_W-1:0] edge_ctr_q, edge_ctr_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic             rise;
  logic             level;
  logic             edge_at_max;
  logic             edge_sat_hit;
  logic [CNT_W-1:0] edge_next;

  sync_edge_detect u_sync (
    .clk_i   (incoming_CLK100MHZ),
    .rst_i   (reset),
    .async_i (measured_signal),
    .level_o (level),
    .rise_o  (rise)
  );

  assign edge_at_max  = &edge_ctr_q;
  assign edge_sat_hit = rise & edge_at_max;
  assign edge_next    = edge_ctr_q + CNT_W'(rise & ~edge_at_max);

  always_comb begin
    state_d     = state_q;
    flush_ctr_d = flush_ctr_q;
    gate_ctr_d  = gate_ctr_q;
    edge_ctr_d  = edge_ctr_q;
    sat_d       = sat_q;
    freq_d      = freq_q;
    valid_d     = 1'b0;
    ovf_d       = ovf_q;
    unique case (state_q)
      FLUSH: begin
        if (flush_ctr_q == FLUSH_LAST) begin
          state_d     = MEASURE;
          flush_ctr_d = 2'd0;
        end else begin
          flush_ctr_d = flush_ctr_q + 2'd1;
        end
      end
      MEASURE: begin
        // A rise in the gate's last cycle still belongs to the ending gate.
        if (gate_ctr_q == GATE_LAST) begin
          gate_ctr_d = '0;
          freq_d     = edge_next;
          ovf_d      = sat_q | edge_sat_hit;
          valid_d    = 1'b1;
          edge_ctr_d = '0;
          sat_d      = 1'b0;
        end else begin
          gate_ctr_d = gate_ctr_q + GW'(1);
          edge_ctr_d = edge_next;
          sat_d      = sat_q | edge_sat_hit;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge incoming_CLK100MHZ) begin
    if (reset) begin
      state_q     <= FLUSH;
      flush_ctr_q <= 2'd0;
      gate_ctr_q  <= '0;
      edge_ctr_q  <= '0;
      sat_q       <= 1'b0;
      freq_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_ctr_q <= flush_ctr_d;
      gate_ctr_q  <= gate_ctr_d;
      edge_ctr_q  <= edge_ctr_d;
      sat_q       <= sat_d;
      freq_q      <= freq_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign freq_count  = freq_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;
  assign dbg_level_o = level;

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_ctr_q, per_ctr_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pvalid_q, pvalid_d;
  logic [CNT_W-1:0] per_next;

  assign per_next = per_ctr_q + CNT_W'(~(&per_ctr_q));

  always_comb begin
    per_ctr_d = per_ctr_q;
    armed_d   = armed_q;
    period_d  = period_q;
    pvalid_d  = 1'b0;
    if (state_q == MEASURE) begin
      // The first rise after reset only arms the counter.
      if (rise) begin
        if (armed_q) begin
          period_d = per_next;
          pvalid_d = 1'b1;
        end
        armed_d   = 1'b1;
        per_ctr_d = '0;
      end else begin
        per_ctr_d = per_next;
      end
    end
  end

  always_ff @(posedge incoming_CLK100MHZ) begin
    if (reset) begin
      per_ctr_q <= '0;
      armed_q   <= 1'b0;
      period_q  <= '0;
      pvalid_q  <= 1'b0;
    end else begin
      per_ctr_q <= per_ctr_d;
      armed_q   <= armed_d;
      period_q  <= period_d;
      pvalid_q  <= pvalid_d;
    end
  end

  assign period_cycles = period_q;
  assign period_valid  = pvalid_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with GATE_CYCLES=1000 (27-bit and 8-bit counter instances).
// Period checks are compiled in when FREQ_METER_PERIOD_EN is defined.
module tb_freq_meter;

  localparam int G = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic gen_sig = 1'b0;
  logic man_sig = 1'b0;
  logic use_man = 1'b0;
  logic sig;
  assign sig = use_man ? man_sig : gen_sig;

  int unsigned per = 0;
  logic hold_level = 1'b0;
  logic track = 1'b0;

  logic [26:0] freq27;
  logic        valid27, ovf27, st27, lvl27;
  logic [7:0]  freq8;
  logic        valid8, ovf8, st8, lvl8;
`ifdef FREQ_METER_PERIOD_EN
  logic [26:0] per27;
  logic        pval27;
  logic [7:0]  per8;
  logic        pval8;
`endif

  freq_meter #(.GATE_CYCLES(G), .CNT_W(27)) dut (
    .incoming_CLK100MHZ (clk),
    .reset              (rst),
    .measured_signal    (sig),
    .freq_count         (freq27),
    .count_valid        (valid27),
    .overflow           (ovf27),
`ifdef FREQ_METER_PERIOD_EN
    .period_cycles      (per27),
    .period_valid       (pval27),
`endif
    .dbg_state_o        (st27),
    .dbg_level_o        (lvl27)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
    .incoming_CLK100MHZ (clk),
    .reset              (rst),
    .measured_signal    (sig),
    .freq_count         (freq8),
    .count_valid        (valid8),
    .overflow           (ovf8),
`ifdef FREQ_METER_PERIOD_EN
    .period_cycles      (per8),
    .period_valid       (pval8),
`endif
    .dbg_state_o        (st8),
    .dbg_level_o        (lvl8)
  );

  // ---------------- stimulus generator + expected period queue ----------------
  logic [31:0] exp_q[$];
  int unsigned tcyc = 0;
  int unsigned last_rise = 0;
  logic        have_rise = 1'b0;
  int unsigned gen_cnt = 0;

  initial begin
    logic nxt;
    forever begin
      @(negedge clk);
      tcyc++;
      if (!track) begin
        have_rise = 1'b0;
        exp_q.delete();
      end
      if (per == 0) begin
        gen_sig = hold_level;
        gen_cnt = 0;
      end else begin
        nxt = (gen_cnt < per / 2);
        if (nxt && !gen_sig && track) begin
          if (have_rise) exp_q.push_back(32'(tcyc - last_rise));
          last_rise = tcyc;
          have_rise = 1'b1;
        end
        gen_sig = nxt;
        gen_cnt = (gen_cnt + 1) % per;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns the number of clock edges until count_valid is seen, or -1 on timeout.
  task automatic wait_valid(input int maxc, output int n);
    logic found;
    n = 0;
    found = 1'b0;
    while (n < maxc && !found) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid27) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int k, o;
    int hi;
    int injected, seen_total, gates_seen;
    logic is_edge;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_freq", 32'(freq27), 0);
    chk("reset_valid", 32'(valid27), 0);
    chk("reset_ovf", 32'(ovf27), 0);
    chk("reset_state", 32'(st27), 0);

    // Period 100 input: 10 edges per gate, first pulse 1003 cycles after release
    per = 100;
    do_reset(2);
    wait_valid(1100, n);
    chk("p100_first_latency", n, 1003);
    chk("p100_freq", 32'(freq27), 10);
    chk("p100_ovf", 32'(ovf27), 0);
    chk("p100_freq8", 32'(freq8), 10);
    chk("p100_ovf8", 32'(ovf8), 0);
    @(negedge clk);
    chk("p100_pulse_width", 32'(valid27), 0);
    chk("p100_hold", 32'(freq27), 10);
    wait_valid(1100, n);
    chk("p100_second_latency", n, G - 1);
    chk("p100_freq_g2", 32'(freq27), 10);

    // Input held high through reset: no false edge
    per = 0;
    hold_level = 1'b1;
    repeat (2) @(negedge clk);
    do_reset(4);
    wait_valid(1100, n);
    chk("high_latency", n, 1003);
    chk("high_freq", 32'(freq27), 0);
    chk("high_freq8", 32'(freq8), 0);
    chk("high_ovf8", 32'(ovf8), 0);

    // Toggle every clock: 500 edges; 8-bit counter saturates
    hold_level = 1'b0;
    per = 2;
    do_reset(4);
    wait_valid(1100, n);
    chk("fast_latency", n, 1003);
    chk("fast_freq", 32'(freq27), 500);
    chk("fast_ovf", 32'(ovf27), 0);
    chk("fast_freq8", 32'(freq8), 255);
    chk("fast_ovf8", 32'(ovf8), 1);

    // Reset mid-gate discards partial gate
    per = 100;
    do_reset(4);
    wait_valid(1100, n);
    chk("midrst_pre_freq", 32'(freq27), 10);
    repeat (600) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_freq", 32'(freq27), 0);
    chk("midrst_valid", 32'(valid27), 0);
    chk("midrst_ovf", 32'(ovf27), 0);
    chk("midrst_state", 32'(st27), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_valid(1100, n);
    chk("midrst_latency", n, 1003);
    chk("midrst_post_freq", 32'(freq27), 10);

    // Manual edges: gate k gets k edges, the last one landing on gate_ctr==G-1
    per = 0;
    hold_level = 1'b0;
    use_man = 1'b1;
    man_sig = 1'b0;
    do_reset(4);
    hi = 0;
    injected = 0;
    seen_total = 0;
    gates_seen = 0;
    for (int t = 1; t <= 5 * G + 3; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid27) begin
        gates_seen++;
        chk("bound_valid_time", t, 3 + G * gates_seen);
        chk("bound_gate_count", 32'(freq27), gates_seen);
        seen_total += int'(freq27);
      end
      k = (t - 1) / G + 1;
      o = t - G * (k - 1);
      is_edge = (k <= 5) && ((o == G) || ((o % 100 == 0) && (o / 100 <= k - 1)));
      if (is_edge) begin
        man_sig = 1'b1;
        hi = 2;
        injected++;
      end else if (hi > 0) begin
        hi--;
        if (hi == 0) man_sig = 1'b0;
      end
    end
    chk("bound_gates_seen", gates_seen, 5);
    chk("bound_total", seen_total, injected);
    use_man = 1'b0;

`ifdef FREQ_METER_PERIOD_EN
    // Period measurement: 100 then 37, each report equals the true edge spacing
    begin
      int reports100, reports37;
      logic [31:0] e;
      per = 0;
      hold_level = 1'b0;
      track = 1'b0;
      do_reset(4);
      repeat (10) @(negedge clk);
      track = 1'b1;
      per = 100;
      reports100 = 0;
      reports37 = 0;
      for (int t = 0; t < 1200; t++) begin
        @(negedge clk);
        if (pval27) begin
          reports100++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          chk("per100_gap", 32'(per27), e);
          chk("per100_value", 32'(per27), 100);
        end
      end
      per = 37;
      for (int t = 0; t < 600; t++) begin
        @(negedge clk);
        if (pval27) begin
          reports37++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          chk("per37_gap", 32'(per27), e);
          if (reports37 > 1) chk("per37_value", 32'(per27), 37);
        end
      end
      chk("per100_reports", reports100, 11);
      chk("per37_enough", 32'(reports37 >= 10), 1);
      track = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the frequency of a slow external or fabric signal against the 100 MHz board clock. It is the measuring end of the clock-divider family: it counts rising edges of `measured_signal` over a fixed gate window and reports edges-per-gate. With the default gate of 1 s, the result is in Hz. It sits at board top level next to the dividers and is used to check their outputs on JA pins or LEDs.

## Interface
- `GATE_CYCLES`, default 100_000_000: gate length in `incoming_CLK100MHZ` cycles (1 s default); must be ≥ 2.
- `CNT_W`, default 27: width of the edge and result counters.
- `incoming_CLK100MHZ`  in  1  system clock, 100 MHz; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `measured_signal`  in  1  asynchronous signal under test.
- `freq_count`  out  CNT_W  rising edges counted in the last completed gate.
- `count_valid`  out  1  one-cycle pulse when `freq_count` updates.
- `overflow`  out  1  high if the last completed gate saturated.
- `period_cycles`  out  CNT_W  clock cycles between the last two rising edges. Present only with the macro.
- `period_valid`  out  1  one-cycle pulse on `period_cycles` update. Present only with the macro.

## Operation
- Input path: 2-FF synchronizer (`s1`, `s2`), then edge register `s3`. A rising edge is `rise = s2 & ~s3`.
- FSM states:
  - `FLUSH`: entered on reset; lasts exactly 3 cycles. The sync/edge pipeline fills and `rise` is ignored. This avoids a false edge when the input is already high at reset.
  - `MEASURE`: entered after FLUSH and stays there until reset.
- In MEASURE:
  - `gate_ctr` runs 0 … GATE_CYCLES-1, then wraps.
  - `edge_ctr` increments on `rise`. It saturates at 2^CNT_W-1 and sets a sticky per-gate `sat` flag.
- Gate end (cycle where `gate_ctr == GATE_CYCLES-1`):
  - `freq_count <= sat_add(edge_ctr, rise)`. An edge in the final cycle belongs to the ending gate.
  - `overflow <=` saturation occurred this gate, including the final add.
  - `count_valid <= 1`.
  - `edge_ctr <= 0`, `sat <= 0`.
- Outputs hold between gates.
- Reset mid-gate discards the partial gate. No partial result is ever reported.

## Timing
- Reset values: `freq_count` = 0, `count_valid` = 0, `overflow` = 0, `period_cycles` = 0, `period_valid` = 0. All internal counters and sync flops are 0, and the state is FLUSH.
- Input latency: an input rising edge produces `rise` 3 clock edges later.
- First `count_valid` fires 3 + GATE_CYCLES cycles after the first clock with `reset` low. After that it fires every GATE_CYCLES cycles, exactly one cycle wide.
- Outputs are registered: `freq_count` and `count_valid` change on the same clock edge.
- Maximum countable rate is one edge per 2 clocks (50 MHz). Faster inputs alias and are not required to be correct.
- Arithmetic is unsigned. Counters never wrap; they saturate.

## Configuration
- `FREQ_METER_PERIOD_EN`: when defined, adds `period_cycles` and `period_valid`.
  - `per_ctr` counts cycles since the last `rise` and saturates at 2^CNT_W-1.
  - On `rise` in MEASURE: `period_cycles <= per_ctr + 1` (saturating), `period_valid <= 1`, `per_ctr <= 0`.
  - The first rise after reset only arms the counter: no `period_valid`.
  - Saturation holds until the next rise and then reports the max value.
- When undefined: the ports and logic are absent, and frequency behaviour is identical.

## Structure
- Shared package `clk_pkg`: `CLK_HZ = 100_000_000`, the default gate constant, and the FSM state enum type `fm_state_t` (FLUSH, MEASURE).
- One natural sub-module: `sync_edge_detect`. It contains the 2-FF synchronizer plus edge register, with outputs `level` and `rise`, and is reusable by other input blocks.
- The gate counter, edge counter, FSM and period logic stay in `freq_meter`.

## Test plan
- GATE_CYCLES=1000, input toggling every 50 cycles (period 100) → `freq_count` = 10 at every `count_valid`, `overflow` = 0. First pulse at cycle 1003 after reset release.
- Input held high through and after reset, GATE_CYCLES=1000 → `freq_count` = 0 (no false edge from FLUSH).
- Input toggling every clock (period 2), GATE_CYCLES=1000 → `freq_count` = 500. With CNT_W=8 → `freq_count` = 255, `overflow` = 1.
- Reset asserted at gate cycle 600 with input at period 100, then released → `freq_count` = 0 and `count_valid` = 0 during reset. Next pulse 1003 cycles after release with value 10.
- Edge timed to arrive as `rise` exactly on `gate_ctr` = 999 → counted in the ending gate, not the next one. Totals across 5 gates equal the edges injected.
- With `FREQ_METER_PERIOD_EN`, input period 100 → first edge gives no `period_valid`, then `period_cycles` = 100 on each rise. Switching to period 37 → next report is the true edge spacing, then 37.
